mem_write_buffer: RTL and testbench

MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

---
 rtl/mem_write_buffer_pkg.sv | 22 ++
 rtl/mem_write_buffer_overlap.sv | 33 +++
 rtl/mem_write_buffer.sv | 106 ++++++++++
 tb/tb_mem_write_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_buffer_pkg.sv
// Shared constants and types for the posted-write buffer: depth default,
// legal write-length window and the dword range representation.
package mem_write_buffer_pkg;

   localparam int DEFAULT_DEPTH = 4;
   localparam logic [2:0] LEN_MIN = 3'd1;
   localparam logic [2:0] LEN_MAX = 3'd4;
   localparam int DWORD_W = 30;

   typedef logic [DWORD_W-1:0] dword_t;

   typedef struct packed {
      logic [31:0] address;
      logic [2:0]  length;
      logic [31:0] data;
   } entry_t;

   function automatic logic is_legal_length(input logic [2:0] len);
      return (len >= LEN_MIN) && (len <= LEN_MAX);
   endfunction

endpackage

// File: rtl/mem_write_buffer_overlap.sv
// Dword-granular range intersection between one write and a pending read;
// a range that wraps past the top of the address space counts as a hit.
module mem_write_buffer_overlap
   import mem_write_buffer_pkg::*;
(
   input  logic        valid,
   input  logic [31:0] a_address,
   input  logic [3:0]  a_length,
   input  logic [31:0] b_address,
   input  logic [3:0]  b_length,
   output logic        hit
);

   logic [31:0] a_last;
   logic [31:0] b_last;
   dword_t      a_start;
   dword_t      a_end;
   dword_t      b_start;
   dword_t      b_end;
   logic        wrap;

   assign a_last  = a_address + {28'd0, a_length} - 32'd1;
   assign b_last  = b_address + {28'd0, b_length} - 32'd1;
   assign a_start = a_address[31:2];
   assign b_start = b_address[31:2];
   assign a_end   = dword_t'(a_last >> 2);
   assign b_end   = dword_t'(b_last >> 2);

   // A wrapped range has no sane ordering, so treat it as overlapping anything.
   assign wrap = (a_end < a_start) || (b_end < b_start);
   assign hit  = valid && (wrap || ((a_start <= b_end) && (b_start <= a_end)));

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write FIFO between the core and the memory stage, with a read-after-
// write hazard check against every buffered entry and the write being accepted.
module mem_write_buffer
   import mem_write_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_req,
   input  logic [31:0] wr_address,
   input  logic [2:0]  wr_length,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   input  logic [31:0] rd_check_address,
   input  logic [3:0]  rd_check_length,
   output logic        rd_hazard,
   output logic        empty,
   output logic        err_bad_length,
   output logic        writeburst_do,
   output logic [31:0] writeburst_address,
   output logic [2:0]  writeburst_length,
   output logic [31:0] writeburst_data_in,
   input  logic        writeburst_done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   entry_t             entries [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic               len_ok;
   logic               accept;
   logic               pop;
   logic [DEPTH-1:0]   entry_valid;
   logic [DEPTH:0]     hits;
   entry_t             head_entry;

   assign len_ok   = is_legal_length(wr_length);
   // Ready depends only on the registered count, so a same-cycle pop never
   // opens a slot for a same-cycle write.
   assign wr_ready = (count < FULL_COUNT);
   assign accept   = wr_req && wr_ready && len_ok;
   assign pop      = writeburst_done && (count != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         err_bad_length <= 1'b0;
      end else begin
         if (accept) tail <= tail + 1'b1;
         if (pop)    head <= head + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_req && !len_ok) err_bad_length <= 1'b1;
      end
   end

   // NOTE: payload storage is deliberately not reset; count alone decides
   // which slots are meaningful, and skipping the reset keeps it plain RAM.
   always_ff @(posedge clk) begin
      if (accept) entries[tail] <= '{address: wr_address, length: wr_length, data: wr_data};
   end

   assign head_entry         = entries[head];
   assign writeburst_do      = (count != '0);
   assign writeburst_address = head_entry.address;
   assign writeburst_length  = head_entry.length;
   assign writeburst_data_in = head_entry.data;
   assign empty              = (count == '0);

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(i) - head;
      assign entry_valid[i] = ({1'b0, offset} < count);

      mem_write_buffer_overlap u_overlap (
         .valid     (entry_valid[i]),
         .a_address (entries[i].address),
         .a_length  ({1'b0, entries[i].length}),
         .b_address (rd_check_address),
         .b_length  (rd_check_length),
         .hit       (hits[i])
      );
   end

   mem_write_buffer_overlap u_overlap_in (
      .valid     (accept),
      .a_address (wr_address),
      .a_length  ({1'b0, wr_length}),
      .b_address (rd_check_address),
      .b_length  (rd_check_length),
      .hit       (hits[DEPTH])
   );

   assign rd_hazard = |hits;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: a behavioural queue model predicts
// acceptance and drain order, plus a table of hazard-range vectors.
module tb_mem_write_buffer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        wr_req;
   logic [31:0] wr_address;
   logic [2:0]  wr_length;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic [31:0] rd_check_address;
   logic [3:0]  rd_check_length;
   logic        rd_hazard;
   logic        empty;
   logic        err_bad_length;
   logic        writeburst_do;
   logic [31:0] writeburst_address;
   logic [2:0]  writeburst_length;
   logic [31:0] writeburst_data_in;
   logic        writeburst_done;

   mem_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .wr_req             (wr_req),
      .wr_address         (wr_address),
      .wr_length          (wr_length),
      .wr_data            (wr_data),
      .wr_ready           (wr_ready),
      .rd_check_address   (rd_check_address),
      .rd_check_length    (rd_check_length),
      .rd_hazard          (rd_hazard),
      .empty              (empty),
      .err_bad_length     (err_bad_length),
      .writeburst_do      (writeburst_do),
      .writeburst_address (writeburst_address),
      .writeburst_length  (writeburst_length),
      .writeburst_data_in (writeburst_data_in),
      .writeburst_done    (writeburst_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] address;
      logic [2:0]  length;
      logic [31:0] data;
   } exp_entry_t;

   typedef struct {
      logic [31:0] wr_addr;
      logic [2:0]  wr_len;
      logic [31:0] rd_addr;
      logic [3:0]  rd_len;
      logic        hazard;
   } hz_vec_t;

   exp_entry_t scoreboard[$];
   int m_count;
   logic m_err;
   int checks;
   int failures;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Entered at posedge+1; drives inputs, checks at the negedge, returns at posedge+1.
   task automatic cycle(input logic req, input logic [31:0] a, input logic [2:0] l,
                        input logic [31:0] d, input logic done);
      exp_entry_t e;
      logic acc, pp;
      wr_req = req; wr_address = a; wr_length = l; wr_data = d; writeburst_done = done;
      @(negedge clk);
      check("wr_ready", {31'd0, wr_ready}, {31'd0, m_count < DEPTH});
      check("empty", {31'd0, empty}, {31'd0, m_count == 0});
      check("writeburst_do", {31'd0, writeburst_do}, {31'd0, m_count != 0});
      check("err_bad_length", {31'd0, err_bad_length}, {31'd0, m_err});
      pp = done && (m_count != 0);
      if (pp) begin
         e = scoreboard.pop_front();
         check("wb_address", writeburst_address, e.address);
         check("wb_length", {29'd0, writeburst_length}, {29'd0, e.length});
         check("wb_data", writeburst_data_in, e.data);
      end
      acc = req && (m_count < DEPTH) && (l >= 3'd1) && (l <= 3'd4);
      if (acc) scoreboard.push_back('{address: a, length: l, data: d});
      if (req && !((l >= 3'd1) && (l <= 3'd4))) m_err = 1'b1;
      m_count = m_count + int'(acc) - int'(pp);
      @(posedge clk);
      #1;
      wr_req = 1'b0; writeburst_done = 1'b0;
   endtask

   task automatic idle(input logic done);
      cycle(1'b0, 32'd0, 3'd0, 32'd0, done);
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH * 4 && m_count > 0; k++) idle(1'b1);
      check("drain_done", {31'd0, m_count == 0}, 32'd1);
      idle(1'b0);
   endtask

   task automatic hazard_check(input string name, input logic [31:0] a, input logic [3:0] l,
                               input logic exp);
      rd_check_address = a; rd_check_length = l;
      #2;
      check(name, {31'd0, rd_hazard}, {31'd0, exp});
   endtask

   task automatic reset_dut(input logic done_during);
      rst_n = 1'b0; wr_req = 1'b0; writeburst_done = done_during;
      @(posedge clk);
      #1;
      rst_n = 1'b1; writeburst_done = 1'b0;
      m_count = 0; m_err = 1'b0;
      scoreboard.delete();
   endtask

   hz_vec_t vecs[8];

   initial begin
      checks = 0; failures = 0; m_count = 0; m_err = 1'b0;
      rst_n = 1'b0; wr_req = 1'b0; wr_address = '0; wr_length = '0; wr_data = '0;
      writeburst_done = 1'b0; rd_check_address = 32'h0000_0000; rd_check_length = 4'd1;

      vecs[0] = '{32'h0000_2003, 3'd2, 32'h0000_2004, 4'd1, 1'b1};
      vecs[1] = '{32'h0000_2003, 3'd2, 32'h0000_2008, 4'd4, 1'b0};
      vecs[2] = '{32'h0000_2003, 3'd2, 32'h0000_1FFC, 4'd4, 1'b0};
      vecs[3] = '{32'h0000_2003, 3'd2, 32'h0000_1FFD, 4'd4, 1'b1};
      vecs[4] = '{32'h0000_2000, 3'd1, 32'h0000_1FF8, 4'd8, 1'b0};
      vecs[5] = '{32'hFFFF_FFFE, 3'd4, 32'h0000_0100, 4'd1, 1'b1};
      vecs[6] = '{32'h0000_5000, 3'd4, 32'hFFFF_FFFC, 4'd8, 1'b1};
      vecs[7] = '{32'hFFFF_FFFC, 3'd4, 32'h0000_0000, 4'd4, 1'b0};

      // Reset state and single-entry latency.
      reset_dut(1'b0);
      idle(1'b0);
      hazard_check("hazard_reset", 32'h0000_2004, 4'd1, 1'b0);
      cycle(1'b1, 32'h0000_1000, 3'd4, 32'hAABB_CCDD, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Fill, reject a fifth write, drain in order.
      for (int i = 0; i < DEPTH + 1; i++)
         cycle(1'b1, 32'h0000_3000 + 32'(i * 4), 3'd4, 32'hC0DE_0000 + 32'(i), 1'b0);
      drain();

      // Full buffer: a same-cycle pop frees a slot only for the next cycle.
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, 32'h0000_4000 + 32'(i * 4), 3'd3, 32'h1111_0000 + 32'(i), 1'b0);
      cycle(1'b1, 32'h0000_4100, 3'd2, 32'h2222_0000, 1'b1);
      cycle(1'b1, 32'h0000_4100, 3'd2, 32'h2222_0001, 1'b0);
      idle(1'b0);
      drain();

      // Hazard against a write being accepted this cycle.
      rd_check_address = 32'h0000_6002; rd_check_length = 4'd1;
      wr_req = 1'b1; wr_address = 32'h0000_6000; wr_length = 3'd4; wr_data = 32'h3333_3333;
      #1;
      check("hazard_accepting", {31'd0, rd_hazard}, 32'd1);
      cycle(1'b1, 32'h0000_6000, 3'd4, 32'h3333_3333, 1'b0);
      drain();

      // Range table.
      for (int v = 0; v < 8; v++) begin
         reset_dut(1'b0);
         cycle(1'b1, vecs[v].wr_addr, vecs[v].wr_len, 32'h5A5A_0000 + 32'(v), 1'b0);
         hazard_check($sformatf("hazard_vec%0d", v), vecs[v].rd_addr, vecs[v].rd_len, vecs[v].hazard);
         drain();
         hazard_check($sformatf("hazard_vec%0d_drained", v), vecs[v].rd_addr, vecs[v].rd_len, 1'b0);
      end

      // Illegal lengths are dropped and latch the sticky error.
      reset_dut(1'b0);
      cycle(1'b1, 32'h0000_7000, 3'd0, 32'hDEAD_0000, 1'b0);
      cycle(1'b1, 32'h0000_7000, 3'd5, 32'hDEAD_0001, 1'b0);
      cycle(1'b1, 32'h0000_7000, 3'd7, 32'hDEAD_0002, 1'b0);
      idle(1'b0);
      idle(1'b0);
      reset_dut(1'b0);
      idle(1'b0);

      // Reset in the middle of a drain discards everything.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h0000_2004, 3'd4, 32'h7777_0000 + 32'(i), 1'b0);
      idle(1'b1);
      hazard_check("hazard_before_reset", 32'h0000_2004, 4'd1, 1'b1);
      reset_dut(1'b1);
      idle(1'b0);
      hazard_check("hazard_after_reset", 32'h0000_2004, 4'd1, 1'b0);
      idle(1'b1);
      idle(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
